// File: rtl/mem_loader.sv
`default_nettype none
// ==========================================================================
// mem_loader : streams a word image into a single-port RAM, then reads it
//              back and compares read/write checksums.         Rev 1.0
// ==========================================================================
module mem_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          DinValid,
  input  logic [15:0]   Din,
  input  logic          DinLast,
  output logic          DinReady,
  output logic [AW-1:0] MemAddr,
  output logic [15:0]   MemData,
  output logic          MemWren,
  input  logic [15:0]   MemQ,
  output logic [AW:0]   Count,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  state_t        r_state, w_state;
  logic [AW-1:0] r_ptr,   w_ptr;
  logic [AW-1:0] r_addr,  w_addr;
  logic [AW:0]   r_count, w_count;
  logic [AW:0]   r_vcnt,  w_vcnt;
  logic [AW:0]   w_count_inc, w_vcnt_inc;
  logic [15:0]   r_wrsum, w_wrsum;
  logic [15:0]   r_rdsum, w_rdsum;
  logic [15:0]   r_data,  w_data;
  logic          r_wren,  w_wren;
  logic          w_xfer;

  assign DinReady    = (r_state == S_LOAD) && (r_count < c_depth);
  assign w_xfer      = DinValid && DinReady;
  assign w_count_inc = r_count + 1'b1;
  assign w_vcnt_inc  = r_vcnt + 1'b1;

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_addr  = r_addr;
    w_count = r_count;
    w_vcnt  = r_vcnt;
    w_wrsum = r_wrsum;
    w_rdsum = r_rdsum;
    w_data  = r_data;
    w_wren  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (r_state != S_IDLE) w_addr = '0;
        if (Start) begin
          w_state = S_LOAD;
          w_ptr   = '0;
          w_count = '0;
          w_wrsum = '0;
          w_rdsum = '0;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_addr  = r_ptr;
          w_data  = Din;
          w_wren  = 1'b1;
          w_ptr   = r_ptr + 1'b1;
          w_count = w_count_inc;
          w_wrsum = r_wrsum + Din;
          if (DinLast || (w_count_inc == c_depth)) w_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_addr  = '0;
        w_rdsum = '0;
        w_vcnt  = '0;
        w_state = S_VERIFY;
      end
      S_VERIFY: begin
        // MemQ in cycle v belongs to the address presented in cycle v; the
        // extra final cycle performs the compare once all samples are summed.
        if (r_vcnt == r_count) begin
          w_addr  = '0;
          w_state = (r_rdsum == r_wrsum) ? S_DONE : S_ERROR;
        end else begin
          w_rdsum = r_rdsum + MemQ;
          w_vcnt  = w_vcnt_inc;
          w_addr  = (w_vcnt_inc < r_count) ? w_vcnt_inc[AW-1:0] : '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_count <= '0;
      r_vcnt  <= '0;
      r_wrsum <= '0;
      r_rdsum <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_addr  <= w_addr;
      r_count <= w_count;
      r_vcnt  <= w_vcnt;
      r_wrsum <= w_wrsum;
      r_rdsum <= w_rdsum;
      r_data  <= w_data;
      r_wren  <= w_wren;
    end
  end

  assign MemAddr = r_addr;
  assign MemData = r_data;
  assign MemWren = r_wren;
  assign Count   = r_count;
  assign Busy    = (r_state == S_LOAD) || (r_state == S_DRAIN) || (r_state == S_VERIFY);
  assign Done    = (r_state == S_DONE);
  assign Error   = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ==========================================================================
// tb_mem_loader : randomized load/verify scenarios against a RAM model and
//                 a queue-free reference of accepted words.     Rev 1.0
// ==========================================================================
module tb_mem_loader;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          DinValid = 1'b0;
  logic [15:0]   Din = '0;
  logic          DinLast = 1'b0;
  logic          DinReady;
  logic [AW-1:0] MemAddr;
  logic [15:0]   MemData;
  logic          MemWren;
  logic [15:0]   MemQ;
  logic [AW:0]   Count;
  logic          Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram     [DEPTH];
  logic [15:0] exp_ram [DEPTH];
  logic [15:0] wv      [256];
  logic        inj_en = 1'b0;

  mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .DinValid(DinValid), .Din(Din),
    .DinLast(DinLast), .DinReady(DinReady), .MemAddr(MemAddr), .MemData(MemData),
    .MemWren(MemWren), .MemQ(MemQ), .Count(Count), .Busy(Busy), .Done(Done),
    .Error(Error)
  );

  always #5 Clk = ~Clk;

  // RAM: registered write, read data follows the registered address
  always @(posedge Clk)
    if (MemWren)
      ram[MemAddr] <= MemData ^ ((inj_en && MemAddr == 7'd5) ? 16'h0001 : 16'h0000);
  assign MemQ = ram[MemAddr];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  32'(MemAddr),  0);
    check({tag, "_data"},  32'(MemData),  0);
    check({tag, "_wren"},  32'(MemWren),  0);
    check({tag, "_count"}, 32'(Count),    0);
    check({tag, "_flags"}, 32'({Done, Error, Busy, DinReady}), 0);
  endtask

  // mode 0: word i = 3i, mode 1: 0x000A+i, mode 2: random
  task automatic run_load(input int n_offer, input bit use_last, input int mode,
                          input int gap_pct, input bit pulses, input bit inject,
                          input int reset_at);
    int n_acc, i, cyc, vt, maxa, mism, last_addr;
    bit loading, exp_xfer, wr_seen;
    logic [15:0] wsum, rsum;
    inj_en = inject;
    for (int k = 0; k < n_offer; k++)
      wv[k] = (mode == 0) ? 16'(k * 3) : (mode == 1) ? 16'(16'h000A + k) : 16'($urandom);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_busy",  32'(Busy), 1);
    check("start_count", 32'(Count), 0);
    check("start_flags", 32'({Done, Error}), 0);

    n_acc = 0; i = 0; cyc = 0; loading = 1'b1; wsum = '0; last_addr = -1;
    while (loading && cyc < 3000) begin
      cyc++;
      DinValid = (i < n_offer) && ($urandom_range(99) >= 32'(gap_pct));
      Din      = (i < n_offer) ? wv[i] : 16'($urandom);
      DinLast  = use_last && (i == n_offer - 1);
      Start    = pulses && ($urandom_range(7) == 0);
      exp_xfer = DinValid && (n_acc < DEPTH);
      check("din_ready", 32'(DinReady), 32'(n_acc < DEPTH));
      if (reset_at > 0 && n_acc == reset_at) begin
        Reset = 1'b1; DinValid = 1'b1; Start = 1'b0;
        tick();
        Reset = 1'b0;
        check_reset_values("reset_mid_load");
        for (int k = 0; k < 4; k++) begin
          tick();
          check("post_reset_idle", 32'({Busy, MemWren, DinReady}), 0);
        end
        DinValid = 1'b0;
        inj_en = 1'b0;
        return;
      end
      tick();
      if (exp_xfer) begin
        check("wr_en",   32'(MemWren), 1);
        check("wr_addr", 32'(MemAddr), 32'(n_acc));
        check("wr_data", 32'(MemData), 32'(Din));
        exp_ram[n_acc] = Din;
        wsum = wsum + Din;
        last_addr = n_acc;
        n_acc++; i++;
        if (DinLast || n_acc == DEPTH) loading = 1'b0;
      end else begin
        check("no_wr", 32'(MemWren), 0);
      end
    end
    check("load_timeout", 32'(loading), 0);
    Start = 1'b0;
    vt = 0;
    if (i < n_offer) begin
      DinValid = 1'b1; Din = wv[i]; DinLast = 1'b0;
      check("ready_after_full", 32'(DinReady), 0);
      tick();
      vt = 1;
      check("no_wr_after_full", 32'(MemWren), 0);
      check("last_wr_addr", 32'(last_addr), 32'(DEPTH - 1));
    end
    DinValid = 1'b0; DinLast = 1'b0;

    maxa = 0; wr_seen = 1'b0;
    while (Busy && vt < 400) begin
      if (vt > 0) begin
        if (32'(MemAddr) > 32'(maxa)) maxa = MemAddr;
        wr_seen |= MemWren;
      end
      Start = pulses && (vt <= n_acc + 1) && ($urandom_range(3) == 0);
      tick();
      vt++;
    end
    Start = 1'b0;
    check("verify_cycles",   32'(vt), 32'(n_acc + 2));
    check("count_final",     32'(Count), 32'(n_acc));
    check("verify_max_addr", 32'(maxa), 32'(n_acc - 1));
    check("verify_no_write", 32'(wr_seen), 0);

    if (inject && n_acc > 5) exp_ram[5] = exp_ram[5] ^ 16'h0001;
    rsum = '0; mism = 0;
    for (int k = 0; k < n_acc; k++) begin
      rsum = rsum + exp_ram[k];
      if (ram[k] !== exp_ram[k]) mism++;
    end
    check("ram_contents", 32'(mism), 0);
    check("done",  32'(Done),  32'(wsum == rsum));
    check("error", 32'(Error), 32'(wsum != rsum));
    check("end_addr_wren", 32'({MemAddr, MemWren}), 0);
    for (int k = 0; k < 3; k++) tick();
    check("flags_held", 32'({Done, Error, Busy}), 32'({wsum == rsum, wsum != rsum, 1'b0}));
    check("count_held", 32'(Count), 32'(n_acc));
    inj_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) ram[k] = '0;
    repeat (3) tick();
    Reset = 1'b0;
    check_reset_values("reset");
    for (int k = 0; k < 5; k++) begin
      DinValid = 1'(($urandom_range(1)));
      Din = 16'($urandom);
      tick();
      check("idle_stays", 32'({Busy, MemWren, Count}), 0);
    end
    DinValid = 1'b0;

    run_load(128, 1'b0, 0,  0, 1'b0, 1'b0, 0);   // full load, no gaps
    run_load(10,  1'b1, 1,  0, 1'b0, 1'b0, 0);   // short load with DinLast
    run_load(20,  1'b1, 2, 20, 1'b0, 1'b1, 0);   // corrupted RAM word 5
    run_load(60,  1'b1, 2, 40, 1'b1, 1'b0, 0);   // gaps + Start pulses
    run_load(128, 1'b0, 2, 10, 1'b0, 1'b0, 50);  // reset at 50th word
    run_load(128, 1'b0, 0,  0, 1'b0, 1'b0, 0);   // full load after reset
    run_load(130, 1'b0, 2, 15, 1'b0, 1'b0, 0);   // overrun

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DEPTH, default 128: number of 16-bit words in the attached single-port RAM; the address width is 7 bits for the default.
REQ-002 Parameter AW, default 7: address width; DEPTH SHALL equal 2**AW.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 DinValid  input  1  Din carries a word.
REQ-007 Din  input  16  word to write.
REQ-008 DinLast  input  1  qualifies Din as the final word of the image.
REQ-009 DinReady  output  1  block accepts Din this cycle.
REQ-010 MemAddr  output  AW  RAM address, registered.
REQ-011 MemData  output  16  RAM write data, registered.
REQ-012 MemWren  output  1  RAM write enable, registered.
REQ-013 MemQ  input  16  RAM read data; the address registered at edge k is sampled by this block at edge k+1.
REQ-014 Count  output  AW+1  number of words written in the current or last load.
REQ-015 Busy  output  1  high in LOAD, DRAIN and VERIFY.
REQ-016 Done  output  1  load verified good; held until Start or Reset.
REQ-017 Error  output  1  checksum mismatch; held until Start or Reset.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DRAIN, VERIFY, DONE and ERROR, with one transition per clock at most.
REQ-019 IDLE, DONE or ERROR with Start=1: next state LOAD; clear Count, the write pointer, both checksums, Done and Error.
REQ-020 DinReady SHALL be 1 only in LOAD with Count < DEPTH; DinReady is a pure decode of the state register and Count.
REQ-021 A transfer occurs on an edge where DinValid=1 and DinReady=1: register MemAddr=ptr, MemData=Din, MemWren=1; ptr+1; Count+1; WrSum += Din mod 2^16.
REQ-022 A cycle with no transfer SHALL register MemWren=0; DinValid without DinReady SHALL be ignored and the data dropped.
REQ-023 A transfer with DinLast=1, or the transfer that makes Count==DEPTH, SHALL move the FSM to DRAIN.
REQ-024 DRAIN (1 cycle): MemWren=0, MemAddr=0, RdSum cleared; the next state is VERIFY.
REQ-025 VERIFY: MemWren=0; MemAddr steps 0..Count-1, one per cycle; each MemQ sample is accumulated into RdSum mod 2^16 one cycle after its address.
REQ-026 VERIFY SHALL last Count+1 cycles and then compare RdSum with WrSum: equal goes to DONE (Done=1), unequal goes to ERROR (Error=1).
REQ-027 MemAddr SHALL never exceed DEPTH-1, and ptr wraps to 0 only when Count reaches DEPTH (the load ends at that point).
REQ-028 Start in LOAD, DRAIN or VERIFY SHALL be ignored.
REQ-029 DONE and ERROR SHALL hold MemWren=0 and MemAddr=0, and Count keeps its final value.
REQ-030 If Start and a completing compare coincide, the compare SHALL win, and Start is ignored that cycle.

Reset
REQ-031 Reset=1 at an edge sets state IDLE, MemAddr=0, MemData=0, MemWren=0, Count=0, Done=0, Error=0, Busy=0, DinReady=0, and both checksums 0.
REQ-032 Reset has priority over every other input, including mid-LOAD (no further write is issued after the reset edge) and mid-VERIFY.
REQ-033 After Reset the block SHALL stay in IDLE until Start.

Verification
REQ-034 Full load with a behavioural 1-cycle RAM model: Start, then 128 words Din=addr*3 with no gaps -> RAM[i]=3i, Count=128, DRAIN, 129 VERIFY cycles, Done=1, Error=0.
REQ-035 Short load: 10 words 0x000A..0x0013 with DinLast on the 10th -> Count=10, MemAddr max 9 in VERIFY, Done=1.
REQ-036 Fault injection: the RAM model corrupts RAM[5] by XOR 0x0001 after the write -> Error=1, Done=0, Count unchanged.
REQ-037 Backpressure and gaps: DinValid toggles randomly and Start is pulsed mid-LOAD -> no duplicated or lost words, Start has no effect, Done=1.
REQ-038 Reset at the 50th word of LOAD -> the next cycle has MemWren=0 and all outputs at their REQ-031 values; a following Start and full load pass with Done=1.
REQ-039 Overrun: 130 words offered without DinLast -> exactly 128 accepted, DinReady=0 after the 128th, and 0x007F is the last write address.
